// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// arm_pkg : shared types and constants for the ARM pipeline front end
// Revision: 1.0
// ============================================================================
package arm_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [31:0] INST_NOP = 32'd0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } if_state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// if_id_reg : IF/ID pipeline register with hold (freeze) and clear (bubble)
// Revision: 1.0
// ============================================================================
module if_id_reg
  import arm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            clear,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_valid
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            valid_q, valid_d;

  // clear wins over hold so a redirect can flush a frozen stage
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (clear) begin
      pc_d    = '0;
      inst_d  = INST_NOP;
      valid_d = 1'b0;
    end else if (!hold) begin
      pc_d    = in_pc;
      inst_d  = in_inst;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= INST_NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign out_pc    = pc_q;
  assign out_inst  = inst_q;
  assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// if_stage : instruction fetch stage - PC, next-PC select, boot/stall FSM
// Revision: 1.0
// ============================================================================
module if_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  if_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     count_q, count_d;
  logic [PC_W-1:0] pc_next_seq;
  logic            reg_hold;
  logic            reg_clear;

  assign pc_next_seq = pc_q + PC_STEP;

  // branch outranks freeze in every state; BOOT burns one cycle with no capture
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    reg_hold  = 1'b1;
    reg_clear = 1'b0;
    if (branch_taken) begin
      pc_d      = branch_addr;
      reg_clear = 1'b1;
      state_d   = RUN;
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        default: begin
          if (freeze) begin
            state_d = STALL;
          end else begin
            pc_d     = pc_next_seq;
            reg_hold = 1'b0;
            count_d  = count_q + 32'd1;
            state_d  = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .hold      (reg_hold),
    .clear     (reg_clear),
    .in_pc     (pc_next_seq),
    .in_inst   (imem_inst),
    .out_pc    (if_id_pc),
    .out_inst  (if_id_inst),
    .out_valid (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign fetch_count = count_q;

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage ARM pipeline; the initiator side of the instruction-memory interface.
- Owns the PC and drives the fetch address to the combinational instruction memory. Captures the returned word into the IF/ID pipeline register.
- Handles hazard freeze, branch redirect from EXE and bubble insertion.
- Also keeps a fetched-instruction counter for debug.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- PC_STEP, 32'd4, byte increment per sequential fetch.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard stall from hazard unit; hold PC and IF/ID.
- branch_taken  in  1  redirect request from EXE, valid this cycle.
- branch_addr  in  32  redirect target byte address.
- imem_addr  out  32  fetch address to instruction memory (= PC).
- imem_inst  in  32  instruction word returned combinationally for imem_addr.
- if_id_pc  out  32  PC+4 of the instruction held in IF/ID.
- if_id_inst  out  32  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_count  out  32  number of instructions accepted into IF/ID.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). No asynchronous logic.
- Reset values:
  - pc = RESET_PC
  - if_id_pc = 0, if_id_inst = 0, if_id_valid = 0
  - fetch_count = 0
  - state = BOOT
- imem_addr = pc, combinational. The memory is zero-wait: imem_inst is sampled the same cycle.
- pc_next_seq = pc + PC_STEP, 32-bit wrap-around with carry discarded (0xFFFFFFFC -> 0x00000000).
- State machine:
  - BOOT: one cycle after reset deassertion. Drives imem_addr = RESET_PC, captures nothing, then goes to RUN. This gives one bubble after reset.
  - RUN: normal fetch.
  - STALL: entered while freeze = 1 and branch_taken = 0. Returns to RUN on the first cycle with freeze = 0.
- Per-edge priority in RUN/STALL, highest first:
  - rst
  - branch_taken: pc <= branch_addr; IF/ID <= bubble (inst = 0, valid = 0, pc = 0); state <= RUN. This overrides freeze.
  - freeze: pc and IF/ID hold; fetch_count holds.
  - normal: pc <= pc_next_seq; if_id_inst <= imem_inst; if_id_pc <= pc_next_seq; if_id_valid <= 1; fetch_count += 1.
- Branch in BOOT: taken. pc <= branch_addr, bubble, go to RUN.
- Latency:
  - Instruction at address A appears on if_id_inst one edge after imem_addr = A in RUN.
  - First valid IF/ID occurs two edges after rst falls.
- Redirect penalty: exactly one bubble from IF. Stages downstream of IF are flushed by their own logic.
- fetch_count wraps modulo 2^32 silently.
- Reset mid-operation: all state returns to reset values on that edge, regardless of freeze or branch_taken.
- branch_addr bits [1:0] are passed through unmodified; alignment is the caller's responsibility.

Decomposition:
- Shared package arm_pkg holds:
  - typedef enum logic [1:0] {BOOT, RUN, STALL} if_state_t
  - constants INST_NOP = 32'd0, PC_W = 32
- One natural sub-module: if_id_reg, the IF/ID pipeline register with hold (freeze) and clear (bubble) controls. The PC register, next-PC mux and FSM stay in if_stage.

Test Plan:
- Reset then run 4 cycles with memory image word0 = 32'hE3A00014, word1 = 32'hE3A01A01 -> imem_addr sequence 0, 0(BOOT), 4, 8; if_id_inst = E3A00014 with if_id_pc = 4, then E3A01A01 with if_id_pc = 8; fetch_count = 2.
- freeze high for 3 cycles at pc = 12 -> imem_addr holds 12, IF/ID unchanged, fetch_count unchanged; after release, next capture has if_id_pc = 16.
- branch_taken = 1 with branch_addr = 32'd112 while freeze = 1 -> next edge pc = 112, if_id_valid = 0, if_id_inst = 0; following edge captures word at 112 with if_id_pc = 116.
- Self-loop target (branch to current pc = 184 every other cycle) -> valid and bubble alternate, fetch_count increments once per pair.
- pc = 32'hFFFFFFFC, no freeze -> next pc = 0, if_id_pc = 0.
- rst asserted mid-run with freeze = 1 and branch_taken = 1 -> all outputs return to reset values on that edge; BOOT bubble repeats.
